// File: rtl/div_result_buffer.sv
// Buffers fixed-latency divider results with their sideband; issue-to-output LATENCY+1 cycles.
// FWFT valid/ready output; upstream stalls on issue_ready_o credits, never on m_ready_i directly.
module div_result_buffer #(
    parameter int QUOT_WIDTH = 8,
    parameter int REM_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int LATENCY    = 10,
    parameter int DEPTH      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issue_i,
    input  logic [TAG_WIDTH-1:0]         issue_tag_i,
    input  logic                         issue_div_zero_i,
    output logic                         issue_ready_o,
    input  logic                         res_valid_i,
    input  logic [QUOT_WIDTH-1:0]        res_quotient_i,
    input  logic [REM_WIDTH-1:0]         res_remainder_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [QUOT_WIDTH-1:0]        m_quotient_o,
    output logic [REM_WIDTH-1:0]         m_remainder_o,
    output logic [TAG_WIDTH-1:0]         m_tag_o,
    output logic                         m_div_zero_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic                  vld;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  div_zero;
    } sb_t;

    typedef struct packed {
        logic [QUOT_WIDTH-1:0] quotient;
        logic [REM_WIDTH-1:0]  remainder;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  div_zero;
    } entry_t;

    sb_t          sb_q [LATENCY];
    entry_t       mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [CW-1:0] outstanding_q;
    logic         err_q;

    sb_t    tap;
    entry_t head;
    logic   full;
    logic   empty;
    logic   pop;
    logic   wr_en;
    logic   issue_acc;
    logic   credit_ret;
    logic   err_set;

    assign tap   = sb_q[LATENCY-1];
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign m_valid_o     = ~empty;
    assign m_quotient_o  = head.quotient;
    assign m_remainder_o = head.remainder;
    assign m_tag_o       = head.tag;
    assign m_div_zero_o  = head.div_zero;
    assign count_o       = wr_ptr_q - rd_ptr_q;
    assign err_o         = err_q;

    assign issue_ready_o = (outstanding_q < CW'(DEPTH));
    assign pop           = m_valid_o & m_ready_i;
    assign issue_acc     = issue_i & issue_ready_o;
    // Results from un-credited issues can still be popped; never let the counter wrap below zero.
    assign credit_ret    = pop & (outstanding_q != '0);

    // A write to a full FIFO is only safe when the head slot is being freed in the same cycle.
    assign wr_en = res_valid_i & tap.vld & (~full | pop);

    assign err_set = (issue_i & ~issue_ready_o)
                   | (res_valid_i ^ tap.vld)
                   | (res_valid_i & tap.vld & full & ~pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                sb_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            sb_q[0] <= sb_t'{vld: issue_i, tag: issue_tag_i, div_zero: issue_div_zero_i};
            for (int i = 1; i < LATENCY; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= entry_t'{quotient:  res_quotient_i,
                                                    remainder: res_remainder_i,
                                                    tag:       tap.tag,
                                                    div_zero:  tap.div_zero};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            outstanding_q <= outstanding_q + CW'(issue_acc) - CW'(credit_ret);
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer: a behavioural fixed-latency divider stub feeds the DUT.
module tb_div_result_buffer;

    localparam int L = 10;
    localparam int D = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       issue_i;
    logic [3:0] issue_tag_i;
    logic       issue_div_zero_i;
    logic       issue_ready_o;
    logic       res_valid_i;
    logic [7:0] res_quotient_i;
    logic [7:0] res_remainder_i;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [7:0] m_quotient_o;
    logic [7:0] m_remainder_o;
    logic [3:0] m_tag_o;
    logic       m_div_zero_o;
    logic [4:0] count_o;
    logic       err_o;

    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       pv [L];
    logic [7:0] pq [L];
    logic [7:0] pr [L];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [3:0] tag;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_dz;
    } vec_t;

    vec_t vecs [6];

    div_result_buffer #(
        .QUOT_WIDTH(8), .REM_WIDTH(8), .TAG_WIDTH(4), .LATENCY(L), .DEPTH(D)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_i          (issue_i),
        .issue_tag_i      (issue_tag_i),
        .issue_div_zero_i (issue_div_zero_i),
        .issue_ready_o    (issue_ready_o),
        .res_valid_i      (res_valid_i),
        .res_quotient_i   (res_quotient_i),
        .res_remainder_i  (res_remainder_i),
        .m_valid_o        (m_valid_o),
        .m_ready_i        (m_ready_i),
        .m_quotient_o     (m_quotient_o),
        .m_remainder_o    (m_remainder_o),
        .m_tag_o          (m_tag_o),
        .m_div_zero_o     (m_div_zero_o),
        .count_o          (count_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running required done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: the divider stub samples issue at the edge, outputs are driven and sampled 1ns later.
    task automatic cyc();
        logic       iv;
        logic       rv;
        logic [7:0] a;
        logic [7:0] b;
        iv = issue_i;
        rv = rst_i;
        a  = dvd;
        b  = dvs;
        @(posedge clk_i);
        #1;
        if (rv) begin
            for (int i = 0; i < L; i++) begin
                pv[i] = 1'b0;
                pq[i] = 8'h00;
                pr[i] = 8'h00;
            end
        end else begin
            for (int i = L-1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pq[i] = pq[i-1];
                pr[i] = pr[i-1];
            end
            pv[0] = iv;
            pq[0] = (b == 8'h00) ? 8'hFF : a / b;
            pr[0] = (b == 8'h00) ? a : a % b;
        end
        res_valid_i     = pv[L-1];
        res_quotient_i  = pq[L-1];
        res_remainder_i = pr[L-1];
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic issue(input logic [3:0] tag, input logic [7:0] a, input logic [7:0] b);
        issue_i          = 1'b1;
        issue_tag_i      = tag;
        issue_div_zero_i = (b == 8'h00);
        dvd              = a;
        dvs              = b;
    endtask

    task automatic idle_issue();
        issue_i          = 1'b0;
        issue_tag_i      = 4'h0;
        issue_div_zero_i = 1'b0;
        dvd              = 8'h00;
        dvs              = 8'h01;
    endtask

    initial begin
        vecs[0] = '{dvd: 8'd200, dvs: 8'd15, tag: 4'd3,  exp_q: 8'h0D, exp_r: 8'h05, exp_dz: 1'b0};
        vecs[1] = '{dvd: 8'd7,   dvs: 8'd0,  tag: 4'd9,  exp_q: 8'hFF, exp_r: 8'h07, exp_dz: 1'b1};
        vecs[2] = '{dvd: 8'd100, dvs: 8'd7,  tag: 4'd1,  exp_q: 8'h0E, exp_r: 8'h02, exp_dz: 1'b0};
        vecs[3] = '{dvd: 8'd255, dvs: 8'd16, tag: 4'd15, exp_q: 8'h0F, exp_r: 8'h0F, exp_dz: 1'b0};
        vecs[4] = '{dvd: 8'd0,   dvs: 8'd5,  tag: 4'd0,  exp_q: 8'h00, exp_r: 8'h00, exp_dz: 1'b0};
        vecs[5] = '{dvd: 8'd9,   dvs: 8'd9,  tag: 4'd6,  exp_q: 8'h01, exp_r: 8'h00, exp_dz: 1'b0};

        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pq[i] = 8'h00;
            pr[i] = 8'h00;
        end
        res_valid_i     = 1'b0;
        res_quotient_i  = 8'h00;
        res_remainder_i = 8'h00;
        m_ready_i       = 1'b0;
        idle_issue();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;

        chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
        chk("rst_m_valid",     32'(m_valid_o),     32'd0);
        chk("rst_count",       32'(count_o),       32'd0);
        chk("rst_err",         32'(err_o),         32'd0);
        chk("rst_m_data",      {8'h00, m_quotient_o, m_remainder_o, 3'b000, m_div_zero_o, m_tag_o}, 32'd0);

        // Single requests: result appears LATENCY+1 cycles after issue, with no bypass.
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].tag, vecs[v].dvd, vecs[v].dvs);
            cyc();
            idle_issue();
            repeat (L-1) cyc();
            chk("vec_no_bypass", 32'(m_valid_o), 32'd0);
            cyc();
            chk("vec_m_valid",  32'(m_valid_o),     32'd1);
            chk("vec_quotient", 32'(m_quotient_o),  32'(vecs[v].exp_q));
            chk("vec_remainder",32'(m_remainder_o), 32'(vecs[v].exp_r));
            chk("vec_tag",      32'(m_tag_o),       32'(vecs[v].tag));
            chk("vec_div_zero", 32'(m_div_zero_o),  32'(vecs[v].exp_dz));
            chk("vec_count",    32'(count_o),       32'd1);
            cyc();
            chk("vec_count_hold", 32'(count_o), 32'd1);
            m_ready_i = 1'b1;
            cyc();
            m_ready_i = 1'b0;
            chk("vec_pop_valid", 32'(m_valid_o), 32'd0);
            chk("vec_pop_count", 32'(count_o),   32'd0);
            chk("vec_err",       32'(err_o),     32'd0);
        end

        // Fill with backpressure, then drain in order with one issue-and-pop at outstanding=15.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fill_ready_15", 32'(issue_ready_o), 32'd1);
            issue(4'(i), 8'(i * 10), 8'd3);
            cyc();
        end
        idle_issue();
        chk("fill_ready_low", 32'(issue_ready_o), 32'd0);
        repeat (9) cyc();
        chk("fill_count_25", 32'(count_o), 32'd15);
        cyc();
        chk("fill_count_26", 32'(count_o), 32'd16);
        chk("fill_ready_26", 32'(issue_ready_o), 32'd0);
        m_ready_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk("drain_valid", 32'(m_valid_o), 32'd1);
            chk("drain_tag",   32'(m_tag_o),   (k < 16) ? 32'(k) : 32'd10);
            if (k == 16) begin
                chk("drain_extra_q", 32'(m_quotient_o),  32'h0A);
                chk("drain_extra_r", 32'(m_remainder_o), 32'h00);
            end
            if (k == 1) begin
                chk("sim_ready_before", 32'(issue_ready_o), 32'd1);
                issue(4'd10, 8'd50, 8'd5);
            end
            cyc();
            idle_issue();
            if (k == 0) chk("drain_ready_back", 32'(issue_ready_o), 32'd1);
            if (k == 1) begin
                chk("sim_ready_after", 32'(issue_ready_o), 32'd1);
                chk("sim_count",       32'(count_o),       32'd14);
                chk("sim_err",         32'(err_o),         32'd0);
            end
        end
        m_ready_i = 1'b0;
        chk("drain_empty", 32'(m_valid_o), 32'd0);
        chk("drain_count", 32'(count_o),   32'd0);
        chk("drain_err",   32'(err_o),     32'd0);

        // Result with no matching issue is dropped and flagged.
        res_valid_i    = 1'b1;
        res_quotient_i = 8'h55;
        cyc();
        chk("orphan_count", 32'(count_o),   32'd0);
        chk("orphan_valid", 32'(m_valid_o), 32'd0);
        chk("orphan_err",   32'(err_o),     32'd1);
        repeat (3) cyc();
        chk("orphan_sticky", 32'(err_o), 32'd1);
        do_reset();
        chk("orphan_rst_err", 32'(err_o), 32'd0);

        // Issue while out of credits: flagged, and the credit count is not bumped.
        for (int i = 0; i < 16; i++) begin
            issue(4'(i), 8'd20, 8'd4);
            cyc();
        end
        issue(4'd7, 8'd20, 8'd4);
        chk("noc_ready_low", 32'(issue_ready_o), 32'd0);
        cyc();
        idle_issue();
        chk("noc_err",   32'(err_o),         32'd1);
        chk("noc_ready", 32'(issue_ready_o), 32'd0);
        repeat (9) cyc();
        chk("noc_count", 32'(count_o), 32'd16);
        m_ready_i = 1'b1;
        cyc();
        m_ready_i = 1'b0;
        chk("noc_ready_after_pop", 32'(issue_ready_o), 32'd1);
        chk("noc_err_sticky",      32'(err_o),         32'd1);
        do_reset();

        // Reset mid-flight with 4 issued, 2 buffered.
        for (int i = 0; i < 4; i++) begin
            issue(4'(i + 2), 8'd40, 8'd6);
            cyc();
        end
        idle_issue();
        repeat (8) cyc();
        chk("mid_count", 32'(count_o), 32'd2);
        do_reset();
        chk("mid_rst_valid", 32'(m_valid_o),     32'd0);
        chk("mid_rst_count", 32'(count_o),       32'd0);
        chk("mid_rst_ready", 32'(issue_ready_o), 32'd1);
        chk("mid_rst_err",   32'(err_o),         32'd0);
        chk("mid_rst_data",  {8'h00, m_quotient_o, m_remainder_o, 3'b000, m_div_zero_o, m_tag_o}, 32'd0);
        issue(4'd5, 8'd81, 8'd9);
        cyc();
        idle_issue();
        repeat (L) cyc();
        chk("post_valid", 32'(m_valid_o),    32'd1);
        chk("post_q",     32'(m_quotient_o), 32'h09);
        chk("post_tag",   32'(m_tag_o),      32'd5);
        chk("post_err",   32'(err_o),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
